// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the up/down bus counter slice.
//   - mode_e   : operating mode encodings carried on the 2-bit mode bus
//   - calc_top : largest legal count value for a given width and modulus
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_UP   = 2'd1,
        MODE_DOWN = 2'd2,
        MODE_LOAD = 2'd3
    } mode_e;

    // A modulus of 0 selects the natural 2**width range. The arithmetic
    // is done in 64 bits so that width == 32 does not overflow.
    function automatic longint unsigned calc_top(input int unsigned     width,
                                                 input longint unsigned modulus);
        longint unsigned span;
        span = (modulus == 64'd0) ? (64'd1 << width) : modulus;
        return span - 64'd1;
    endfunction

endpackage : counter_pkg

// File: rtl/modulo_step.sv
// -----------------------------------------------------------------------------
// modulo_step
//   Purely combinational next-value logic for a modulo-(TOP+1) counter.
//
//   Ports:
//     value_i  - current registered count
//     mode_i   - hold / up / down / load
//     cin_i    - count enable (gates up and down only)
//     load_i   - data to capture in load mode
//     next_o   - value to register on the next edge
//     wrap_o   - next edge wraps TOP->0 (up) or 0->TOP (down)
//     clamp_o  - load data exceeds TOP and is clamped to TOP
//     tc_o     - terminal-count carry for cascading (combinational)
// -----------------------------------------------------------------------------
module modulo_step
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH-1:0] TOP  = '1
) (
    input  logic [WIDTH-1:0] value_i,
    input  mode_e            mode_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] load_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o,
    output logic             clamp_o,
    output logic             tc_o
);

    // One extra bit so the increment carry and decrement borrow are visible
    // rather than silently dropped.
    logic [WIDTH:0] value_ext;
    logic [WIDTH:0] load_ext;
    logic [WIDTH:0] top_ext;
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;
    logic [WIDTH:0] one_ext;
    logic           at_top;
    logic           at_zero;

    assign one_ext   = {{WIDTH{1'b0}}, 1'b1};
    assign value_ext = {1'b0, value_i};
    assign load_ext  = {1'b0, load_i};
    assign top_ext   = {1'b0, TOP};
    assign inc_ext   = value_ext + one_ext;
    assign dec_ext   = value_ext - one_ext;

    assign at_top  = (value_i == TOP);
    assign at_zero = (value_i == '0);

    // Carry to the next stage fires in the same cycle the wrap is armed,
    // so a chained stage steps on the very same edge.
    assign tc_o = cin_i & (((mode_i == MODE_UP) & at_top) |
                           ((mode_i == MODE_DOWN) & at_zero));

    always_comb begin
        next_o  = value_i;
        wrap_o  = 1'b0;
        clamp_o = 1'b0;
        unique case (mode_i)
            MODE_HOLD: begin
                next_o = value_i;
            end
            MODE_UP: begin
                if (cin_i) begin
                    // Incrementing past TOP (including the 2**WIDTH carry)
                    // wraps to zero.
                    if (inc_ext > top_ext) begin
                        next_o = '0;
                        wrap_o = 1'b1;
                    end else begin
                        next_o = inc_ext[WIDTH-1:0];
                    end
                end
            end
            MODE_DOWN: begin
                if (cin_i) begin
                    // Borrow out of the extended word means we were at zero.
                    if (dec_ext[WIDTH]) begin
                        next_o = TOP;
                        wrap_o = 1'b1;
                    end else begin
                        next_o = dec_ext[WIDTH-1:0];
                    end
                end
            end
            MODE_LOAD: begin
                if (load_ext > top_ext) begin
                    next_o  = TOP;
                    clamp_o = 1'b1;
                end else begin
                    next_o = load_i;
                end
            end
        endcase
    end

endmodule : modulo_step

// File: rtl/updown_bus_counter.sv
// -----------------------------------------------------------------------------
// updown_bus_counter
//   Cascadable modulo up/down counter with a bidirectional data bus.
//   The counter value is driven onto fio unless the block is loading,
//   in which case fio is released and its value is captured on the edge.
//
//   Ports:
//     clk      - clock, all state updates on the rising edge
//     rst      - synchronous active-high reset
//     cin      - count enable / cascade carry-in (up and down only)
//     m        - mode: 0 hold, 1 up, 2 down, 3 load
//     fio      - bidirectional data bus
//     oe       - high while the block drives fio (m != 3)
//     fout     - registered count value, always 0..TOP
//     cout     - combinational terminal-count carry
//     mo       - registered copy of m from the previous cycle
//     wrap     - one-cycle pulse after a wrap-around
//     load_err - one-cycle pulse after an out-of-range load was clamped
// -----------------------------------------------------------------------------
module updown_bus_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MODULUS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cin,
    input  logic [1:0]       m,
    inout  wire  [WIDTH-1:0] fio,
    output logic             oe,
    output logic [WIDTH-1:0] fout,
    output logic             cout,
    output logic [1:0]       mo,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(calc_top(WIDTH, MODULUS));

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("updown_bus_counter: WIDTH must be in 2..32");
        end
        if (MODULUS == 1 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
            $error("updown_bus_counter: MODULUS must be 0 or 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] fout_q,     fout_d;
    logic [1:0]       mo_q;
    logic             wrap_q,     wrap_d;
    logic             load_err_q, load_err_d;
    logic             tc;
    mode_e            mode;

    assign mode = mode_e'(m);

    modulo_step #(
        .WIDTH (WIDTH),
        .TOP   (TOP)
    ) u_step (
        .value_i (fout_q),
        .mode_i  (mode),
        .cin_i   (cin),
        .load_i  (fio),
        .next_o  (fout_d),
        .wrap_o  (wrap_d),
        .clamp_o (load_err_d),
        .tc_o    (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fout_q     <= '0;
            mo_q       <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            fout_q     <= fout_d;
            mo_q       <= m;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // Bus direction depends only on the live mode, so it stays valid
    // through reset.
    assign oe  = (mode != MODE_LOAD);
    assign fio = oe ? fout_q : 'z;

    assign fout     = fout_q;
    assign cout     = tc;
    assign mo       = mo_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule : updown_bus_counter

// File: tb/tb_updown_bus_counter.sv
module tb_updown_bus_counter;

    localparam int TOP = 199;

    typedef struct packed {
        logic [7:0] fout;
        logic [1:0] mo;
        logic       wrap;
        logic       lerr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       cin;
    logic [1:0] m;
    logic [7:0] tb_bus;
    logic       tb_bus_en;
    wire  [7:0] fio;
    logic       oe;
    logic [7:0] fout;
    logic       cout;
    logic [1:0] mo;
    logic       wrap;
    logic       load_err;

    // Cascade pair
    logic       c_rst;
    logic [1:0] c_m;
    logic       c_cin;
    wire  [3:0] fio_lo;
    wire  [3:0] fio_hi;
    logic       oe_lo, oe_hi;
    logic [3:0] fout_lo, fout_hi;
    logic       cout_lo, cout_hi;
    logic [1:0] mo_lo, mo_hi;
    logic       wrap_lo, wrap_hi;
    logic       lerr_lo, lerr_hi;

    int   checks;
    int   errors;
    exp_t exp_q[$];
    int   cq[$];
    int   mdl_f;
    logic [1:0] mdl_mo;

    assign fio = tb_bus_en ? tb_bus : 'z;

    updown_bus_counter #(.WIDTH(8), .MODULUS(200)) dut (
        .clk(clk), .rst(rst), .cin(cin), .m(m), .fio(fio), .oe(oe),
        .fout(fout), .cout(cout), .mo(mo), .wrap(wrap), .load_err(load_err)
    );

    updown_bus_counter #(.WIDTH(4), .MODULUS(0)) u_lo (
        .clk(clk), .rst(c_rst), .cin(c_cin), .m(c_m), .fio(fio_lo), .oe(oe_lo),
        .fout(fout_lo), .cout(cout_lo), .mo(mo_lo), .wrap(wrap_lo), .load_err(lerr_lo)
    );

    updown_bus_counter #(.WIDTH(4), .MODULUS(0)) u_hi (
        .clk(clk), .rst(c_rst), .cin(cout_lo), .m(c_m), .fio(fio_hi), .oe(oe_hi),
        .fout(fout_hi), .cout(cout_hi), .mo(mo_hi), .wrap(wrap_hi), .load_err(lerr_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, advance the reference model and queue the values the
    // registered outputs must show after the coming edge.
    task automatic drive(input logic r, input logic [1:0] mm, input logic c,
                         input logic [7:0] bus, input logic bus_en);
        exp_t e;
        rst = r; m = mm; cin = c; tb_bus = bus; tb_bus_en = bus_en;
        e = '0;
        if (r) begin
            mdl_f  = 0;
            mdl_mo = 2'd0;
        end else begin
            case (mm)
                2'd1: if (c) begin
                    if (mdl_f == TOP) begin mdl_f = 0; e.wrap = 1'b1; end
                    else mdl_f = mdl_f + 1;
                end
                2'd2: if (c) begin
                    if (mdl_f == 0) begin mdl_f = TOP; e.wrap = 1'b1; end
                    else mdl_f = mdl_f - 1;
                end
                2'd3: begin
                    if (int'(bus) > TOP) begin mdl_f = TOP; e.lerr = 1'b1; end
                    else mdl_f = int'(bus);
                end
                default: ;
            endcase
            mdl_mo = mm;
        end
        e.fout = mdl_f[7:0];
        e.mo   = mdl_mo;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1'b1, 2'd0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (oe !== 1'b1) begin
            errors++;
            $display("FAIL reset_oe: got %b want 1", oe);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({fout, mo, wrap, load_err} !== e) begin
            errors++;
            $display("FAIL reset_state: got fout=%0d mo=%0d wrap=%b lerr=%b want fout=%0d mo=%0d wrap=%b lerr=%b",
                     fout, mo, wrap, load_err, e.fout, e.mo, e.wrap, e.lerr);
        end
    endtask

    task automatic test_up_run();
        exp_t e;
        int   cur;
        int   wraps;
        int   couts;
        wraps = 0;
        couts = 0;
        for (int i = 0; i < 200; i++) begin
            cur = mdl_f;
            drive(1'b0, 2'd1, 1'b1, 8'h00, 1'b0);
            checks++;
            if (cout !== (cur == TOP) || fio !== fout) begin
                errors++;
                $display("FAIL up_comb cyc %0d: cout=%b fio=%0d fout=%0d want cout=%b fio=fout",
                         i, cout, fio, fout, (cur == TOP));
            end
            if (cout === 1'b1) couts++;
            tick();
            e = exp_q.pop_front();
            if (wrap === 1'b1) wraps++;
            checks++;
            if ({fout, mo, wrap, load_err} !== e) begin
                errors++;
                $display("FAIL up_run cyc %0d: got fout=%0d mo=%0d wrap=%b lerr=%b want fout=%0d mo=%0d wrap=%b lerr=%b",
                         i, fout, mo, wrap, load_err, e.fout, e.mo, e.wrap, e.lerr);
            end
        end
        checks++;
        if (wraps != 1 || couts != 1) begin
            errors++;
            $display("FAIL up_pulses: wraps=%0d couts=%0d want 1 and 1", wraps, couts);
        end
    endtask

    task automatic test_down();
        exp_t e;
        // one wrapping step, then enable low for three cycles
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd2, (i == 0), 8'h00, 1'b0);
            checks++;
            if (cout !== (i == 0)) begin
                errors++;
                $display("FAIL down_cout step %0d: got %b want %b", i, cout, (i == 0));
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({fout, mo, wrap, load_err} !== e) begin
                errors++;
                $display("FAIL down step %0d: got fout=%0d mo=%0d wrap=%b lerr=%b want fout=%0d mo=%0d wrap=%b lerr=%b",
                         i, fout, mo, wrap, load_err, e.fout, e.mo, e.wrap, e.lerr);
            end
        end
        // plain decrements
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd2, 1'b1, 8'h00, 1'b0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({fout, wrap} !== {e.fout, e.wrap}) begin
                errors++;
                $display("FAIL down_dec %0d: got fout=%0d wrap=%b want fout=%0d wrap=%b",
                         i, fout, wrap, e.fout, e.wrap);
            end
        end
    endtask

    task automatic test_load();
        exp_t e;
        logic [7:0] vals [0:5];
        vals[0] = 8'h37; vals[1] = 8'hFA; vals[2] = 8'd199;
        vals[3] = 8'd200; vals[4] = 8'h00; vals[5] = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 2'd3, i[0], vals[i], 1'b1);
            checks++;
            if (oe !== 1'b0 || fio !== vals[i] || cout !== 1'b0) begin
                errors++;
                $display("FAIL load_bus %0d: oe=%b fio=%h cout=%b want oe=0 fio=%h cout=0",
                         i, oe, fio, cout, vals[i]);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({fout, mo, wrap, load_err} !== e) begin
                errors++;
                $display("FAIL load %0d: got fout=%h mo=%0d wrap=%b lerr=%b want fout=%h mo=%0d wrap=%b lerr=%b",
                         i, fout, mo, wrap, load_err, e.fout, e.mo, e.wrap, e.lerr);
            end
        end
        // hold after a clamped load: pulse must drop, value must stay
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, i[0], 8'h00, 1'b0);
            checks++;
            if (oe !== 1'b1 || fio !== fout) begin
                errors++;
                $display("FAIL hold_bus %0d: oe=%b fio=%h fout=%h want oe=1 fio=fout", i, oe, fio, fout);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({fout, mo, wrap, load_err} !== e) begin
                errors++;
                $display("FAIL hold %0d: got fout=%h mo=%0d wrap=%b lerr=%b want fout=%h mo=%0d wrap=%b lerr=%b",
                         i, fout, mo, wrap, load_err, e.fout, e.mo, e.wrap, e.lerr);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        // load 119, step to 120, reset while counting up, resume
        // then load TOP and reset while a wrap would be due
        logic [1:0] ms [0:6];
        logic       rs [0:6];
        logic [7:0] ds [0:6];
        ms[0] = 2'd3; rs[0] = 1'b0; ds[0] = 8'd119;
        ms[1] = 2'd1; rs[1] = 1'b0; ds[1] = 8'd0;
        ms[2] = 2'd1; rs[2] = 1'b1; ds[2] = 8'd0;
        ms[3] = 2'd1; rs[3] = 1'b0; ds[3] = 8'd0;
        ms[4] = 2'd3; rs[4] = 1'b0; ds[4] = 8'd199;
        ms[5] = 2'd1; rs[5] = 1'b1; ds[5] = 8'd0;
        ms[6] = 2'd1; rs[6] = 1'b0; ds[6] = 8'd0;
        for (int i = 0; i < 7; i++) begin
            drive(rs[i], ms[i], 1'b1, ds[i], (ms[i] == 2'd3));
            if (rs[i]) begin
                checks++;
                if (oe !== 1'b1 || fio !== fout) begin
                    errors++;
                    $display("FAIL rst_bus %0d: oe=%b fio=%h fout=%h want oe=1 fio=fout", i, oe, fio, fout);
                end
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({fout, mo, wrap, load_err} !== e) begin
                errors++;
                $display("FAIL reset_mid %0d: got fout=%0d mo=%0d wrap=%b lerr=%b want fout=%0d mo=%0d wrap=%b lerr=%b",
                         i, fout, mo, wrap, load_err, e.fout, e.mo, e.wrap, e.lerr);
            end
        end
    endtask

    task automatic test_cascade();
        int n;
        int want;
        c_rst = 1'b1; c_m = 2'd0; c_cin = 1'b0;
        tick();
        c_rst = 1'b0; c_m = 2'd1; c_cin = 1'b1;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            n = n + 1;
            cq.push_back(n % 256);
            tick();
            want = cq.pop_front();
            checks++;
            if ({fout_hi, fout_lo} !== want[7:0]) begin
                errors++;
                $display("FAIL cascade cyc %0d: got %0d want %0d", i, {fout_hi, fout_lo}, want);
            end
        end
        checks++;
        if ({fout_hi, fout_lo} !== 8'd44) begin
            errors++;
            $display("FAIL cascade_final: got %0d want 44", {fout_hi, fout_lo});
        end
        c_m = 2'd0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mdl_f     = 0;
        mdl_mo    = 2'd0;
        rst       = 1'b1;
        m         = 2'd0;
        cin       = 1'b0;
        tb_bus    = 8'h00;
        tb_bus_en = 1'b0;
        c_rst     = 1'b1;
        c_m       = 2'd0;
        c_cin     = 1'b0;
        #1;
        test_reset();
        test_up_run();
        test_down();
        test_load();
        test_reset_mid();
        test_cascade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_updown_bus_counter

// File: doc/updown_bus_counter.md
UPDOWN_BUS_COUNTER -- requirements
Module: updown_bus_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: counter and data bus width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter MODULUS, default 0: count range; 0 means 2**WIDTH, otherwise the legal range is 2..2**WIDTH.
REQ-003 Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port cin, input, 1 bit: count enable / cascade carry-in; gates up and down counting only.
REQ-006 Port m, input, 2 bits: mode; 0 = hold, 1 = up, 2 = down, 3 = load.
REQ-007 Port fio, inout, WIDTH bits: bidirectional data bus.
REQ-008 Port oe, output, 1 bit: high while the block drives fio.
REQ-009 Port fout, output, WIDTH bits: registered count value.
REQ-010 Port cout, output, 1 bit: combinational terminal-count carry for cascading.
REQ-011 Port mo, output, 2 bits: registered copy of m from the previous cycle.
REQ-012 Port wrap, output, 1 bit: registered one-cycle pulse on wrap-around.
REQ-013 Port load_err, output, 1 bit: registered one-cycle pulse when an out-of-range load value is clamped.

Function
REQ-014 Let TOP = (MODULUS == 0 ? 2**WIDTH : MODULUS) - 1; fout SHALL always be in the range 0..TOP.
REQ-015 In mode 0, fout SHALL hold its value regardless of cin.
REQ-016 In mode 1 with cin=1, fout SHALL become fout+1, except when fout==TOP, where it SHALL become 0 and wrap SHALL pulse the next cycle.
REQ-017 In mode 2 with cin=1, fout SHALL become fout-1, except when fout==0, where it SHALL become TOP and wrap SHALL pulse.
REQ-018 In modes 1 and 2 with cin=0, fout SHALL hold and wrap SHALL stay low.
REQ-019 In mode 3, fout SHALL capture fio on the next edge, independent of cin; a value above TOP SHALL load TOP and pulse load_err.
REQ-020 The load latency SHALL be one cycle: a value driven on fio at edge N SHALL appear on fout after edge N.
REQ-021 oe SHALL equal (m != 3), combinationally; fio SHALL carry fout when oe=1 and be high-impedance when oe=0.
REQ-022 cout SHALL equal cin & ((m==1 & fout==TOP) | (m==2 & fout==0)), combinationally, so that chained counters step on the same edge.
REQ-023 The next-value arithmetic SHALL use WIDTH+1 bits internally; no intermediate value SHALL truncate silently.
REQ-024 wrap and load_err SHALL be single-cycle pulses, both low in any cycle without the triggering event.
REQ-025 A mode change SHALL take effect on the edge where it is sampled; there SHALL be no pipeline between m and the fout update.

Reset
REQ-026 When rst=1 at a rising edge: fout=0, mo=0, wrap=0, load_err=0; reset SHALL take priority over every mode.
REQ-027 After a reset asserted mid-count or mid-load, counting SHALL restart from 0 on the first edge with rst=0.
REQ-028 oe and cout SHALL remain combinational during reset; the bus SHALL not float while m != 3.

Structure
REQ-029 Mode encodings (HOLD, UP, DOWN, LOAD) SHALL reside in shared package counter_pkg, together with a function computing TOP from WIDTH and MODULUS.
REQ-030 The next-value and terminal-count logic SHALL be the sub-module modulo_step (inputs: value, mode, cin, load data; outputs: next value, wrap, clamp); the top level SHALL hold the registers and the tristate driver only.

Verification
REQ-031 Bench with WIDTH=8, MODULUS=200: reset, then m=1, cin=1 for 200 cycles -> fout runs 0..199, then 0; wrap pulses once; cout=1 exactly in the cycle fout==199.
REQ-032 From fout=0: m=2, cin=1, one edge -> fout=199, wrap=1 for one cycle; m=2, cin=0 -> fout holds at 199.
REQ-033 m=3, fio driven 0x37 -> fout=0x37 next cycle, oe=0 during the load; m=3, fio=0xFA -> fout=199 (0xC7), load_err=1 for one cycle.
REQ-034 Two instances (WIDTH=4, MODULUS=0) with cout of the low instance feeding cin of the high one, m=1 for 300 cycles -> concatenated value = 300 mod 256 = 44.
REQ-035 rst=1 during an up-count at fout=120 -> next cycle fout=0, mo=0, no wrap pulse; counting resumes at 1 after rst falls.
REQ-036 m=1 and oe=1 -> fio mirrors fout every cycle; m=3 -> fio is high-impedance from the block side.
